// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Each accepted op spends one cycle in EXEC (ALU sees registered inputs) and
// one cycle in RESP (response pulse to the owner). A new op can be accepted
// in RESP, so a continuously loaded arbiter completes one op every 2 cycles.
module alu_share_arbiter #(
  parameter int unsigned data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [3:0]            req0_op,
  input  logic [data_width-1:0] req0_a,
  input  logic [data_width-1:0] req0_b,
  output logic                  rsp0_valid,
  output logic [data_width-1:0] rsp0_result,
  output logic                  rsp0_bcond,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [3:0]            req1_op,
  input  logic [data_width-1:0] req1_a,
  input  logic [data_width-1:0] req1_b,
  output logic                  rsp1_valid,
  output logic [data_width-1:0] rsp1_result,
  output logic                  rsp1_bcond,

  output logic [3:0]            alu_op,
  output logic [data_width-1:0] alu_in_1,
  output logic [data_width-1:0] alu_in_2,
  input  logic [data_width-1:0] alu_result,
  input  logic                  alu_bcond,

  output logic                  busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [3:0]            op_q, op_d;
  logic [data_width-1:0] in_1_q, in_1_d;
  logic [data_width-1:0] in_2_q, in_2_d;
  logic [data_width-1:0] res0_q, res0_d;
  logic [data_width-1:0] res1_q, res1_d;
  logic                  bcond0_q, bcond0_d;
  logic                  bcond1_q, bcond1_d;

  logic any_valid;
  logic win_id;
  logic window;
  logic accept;

  // Arbitration: a lone requester always wins; on contention the one not
  // granted last time wins. The winner's valid is high by construction, so
  // an open window plus any valid is already a handshake.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      win_id = ~last_grant_q;
    end else begin
      win_id = req1_valid;
    end
    window     = (state_q == StIdle) || (state_q == StResp);
    accept     = window && any_valid;
    req0_ready = accept && !win_id;
    req1_ready = accept && win_id;
  end

  // Next-state logic: FSM sequencing, operand latching and result capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    in_1_d       = in_1_q;
    in_2_d       = in_2_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    bcond0_d     = bcond0_q;
    bcond1_d     = bcond1_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StResp;
        // Only the owner's response registers change; the other side holds.
        if (owner_q) begin
          res1_d   = alu_result;
          bcond1_d = alu_bcond;
        end else begin
          res0_d   = alu_result;
          bcond0_d = alu_bcond;
        end
      end
      StResp: begin
        state_d = accept ? StExec : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // accept is only ever true in IDLE or RESP.
    if (accept) begin
      owner_d      = win_id;
      last_grant_d = win_id;
      if (win_id) begin
        op_d   = req1_op;
        in_1_d = req1_a;
        in_2_d = req1_b;
      end else begin
        op_d   = req0_op;
        in_1_d = req0_a;
        in_2_d = req0_b;
      end
    end
  end

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      in_1_q       <= '0;
      in_2_q       <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
      bcond0_q     <= 1'b0;
      bcond1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      in_1_q       <= in_1_d;
      in_2_q       <= in_2_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      bcond0_q     <= bcond0_d;
      bcond1_q     <= bcond1_d;
    end
  end

  // Output decode: response pulse goes only to the owner during RESP.
  always_comb begin
    busy        = (state_q == StExec);
    rsp0_valid  = (state_q == StResp) && !owner_q;
    rsp1_valid  = (state_q == StResp) && owner_q;
    rsp0_result = res0_q;
    rsp0_bcond  = bcond0_q;
    rsp1_result = res1_q;
    rsp1_bcond  = bcond1_q;
    alu_op      = op_q;
    alu_in_1    = in_1_q;
    alu_in_2    = in_2_q;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the PC/address-increment path and the instruction-execute path of the multi-cycle core.
- Accepts one operation at a time through a valid/ready handshake and arbitrates round-robin.
- Drives registered op/operands to the ALU, captures result and branch condition, and returns them to the owning requester as a one-cycle response pulse.

Parameters:
- data_width, 32, operand/result width; must match the attached ALU.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  arbiter accepts requester 0 this cycle
- req0_op  in  4  ALU op code (`ALU_* encodings from opcodes.v)
- req0_a  in  data_width  operand 1
- req0_b  in  data_width  operand 2
- rsp0_valid  out  1  response pulse for requester 0
- rsp0_result  out  data_width  captured alu_result
- rsp0_bcond  out  1  captured alu_bcond
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_result, rsp1_bcond: same as requester 0
- alu_op  out  4  to ALU
- alu_in_1  out  data_width  to ALU
- alu_in_2  out  data_width  to ALU
- alu_result  in  data_width  from ALU, combinational
- alu_bcond  in  1  from ALU, combinational
- busy  out  1  high in EXEC

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous active-high.
- Reset values:
  - State = IDLE; last_grant = 1, so requester 0 wins first.
  - alu_op, alu_in_1, alu_in_2 = 0.
  - All rsp*_valid, rsp*_result, rsp*_bcond = 0; busy = 0.
- Winner (combinational):
  - Only one reqN_valid high: that requester wins.
  - Both high: the requester != last_grant wins.
  - Neither high: no winner.
- reqN_ready = (state IDLE or RESP) and winner == N. At most one ready is high.
- Ready depends on both valids. Requesters must not derive valid from ready.
- Handshake: valid && ready at a rising edge accepts the operation.
  - Latch op/a/b into alu_op/alu_in_1/alu_in_2 registers.
  - Set owner = N and last_grant = N; go to EXEC.
  - Any valid held without ready is not consumed.
- States:
  - IDLE: no response. Accept → EXEC; else stay.
  - EXEC: busy = 1; ALU sees the registered inputs for the whole cycle. At the edge, capture alu_result/alu_bcond into rsp{owner}_result/bcond and go to RESP. No acceptance in EXEC.
  - RESP: rsp{owner}_valid = 1 for exactly this cycle; the other rsp_valid = 0. Accept → EXEC (back-to-back), else → IDLE.
- Latency:
  - Accept at edge E0; EXEC during E0..E1; rsp valid during E1..E2.
  - Throughput: one op per 2 cycles under continuous load.
- Held values:
  - rsp*_result/bcond hold their last value when not valid; only the owner's set updates.
  - ALU input registers hold their last operation while IDLE.
- Ops pass through unmodified. Branch ops return result 0 and a meaningful bcond; arithmetic ops return bcond 0, as produced by the ALU.
- No response back-pressure: a requester must sample in the RESP cycle.
- Reset mid-EXEC or mid-RESP: the in-flight op is discarded, no response pulse is emitted, and all reset values apply immediately (asynchronously).
- Fairness: under continuous dual requests, grants strictly alternate. A lone requester is granted every available slot.

Test Plan:
- Single op: after reset, req0 `ALU_ADD a=5 b=7 held 1 cycle → req0_ready=1 at accept; busy=1 next cycle; rsp0_valid=1 one cycle later with rsp0_result=12, rsp0_bcond=0; rsp1_valid stays 0.
- Contention: both valid at the first edge after reset (req0 `ALU_SUB 10,3; req1 `ALU_XOR 0xF0,0xFF) → req0 served first (result 7); req1 accepted in the RESP cycle, result 0x0F two cycles later.
- Alternation: both valid continuously for 6 grants → grant order 0,1,0,1,0,1; rsp pulses every 2 cycles alternating rsp0/rsp1.
- Branch: req1 `ALU_BEQ 4,4 then `ALU_BNE 4,4 → rsp1_bcond=1 then 0, rsp1_result=0 both times; second accepted back-to-back from RESP.
- Reset mid-op: accept req0 `ALU_OR 1,2; assert reset during EXEC → all outputs 0 immediately, no rsp0_valid pulse; after release, req1 alone is granted and returns the correct result.
- Lone requester: req1 valid continuously with `ALU_SLL 1,k (k=0..3), req0 idle → every op granted with no idle gap; results 1,2,4,8.
